// File: rtl/test_check_pattern_pkg.sv
// Constants and state encodings for the test-pattern stream (ethertype 0x88B5).
// S_IDLE..S_DATA are the encodings shared with the pattern generator; S_DROP is checker-only.
package test_check_pattern_pkg;

    localparam logic [15:0] ETH_TYPE_PATTERN = 16'h88B5;
    localparam logic [7:0]  PATTERN_FLAG     = 8'h07;
    localparam int          ZERO_FIELD_LEN   = 3;
    localparam logic [47:0] BROADCAST_MAC    = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_TYPE_FLAG    = 3'd1,
        S_TIMESTAMP    = 3'd2,
        S_3ZEROS       = 3'd3,
        S_PACKET_INDEX = 3'd4,
        S_DATA         = 3'd5,
        S_DROP         = 3'd6
    } state_t;

    function automatic logic mac_accepted(input logic [47:0] dest, input logic [47:0] local_mac);
        return (dest == local_mac) || (dest == BROADCAST_MAC);
    endfunction

endpackage

// File: rtl/test_pattern_stats.sv
// Frame statistics: good/bad/lost/drop counters with synchronous clear.
// Lost frames are the forward index gap between consecutive good frames; backward jumps are resyncs.
module test_pattern_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_stats_i,
    input  logic        frame_good_i,
    input  logic        frame_bad_i,
    input  logic        frame_drop_i,
    input  logic [15:0] frame_index_i,
    output logic [31:0] good_count_o,
    output logic [31:0] bad_count_o,
    output logic [31:0] lost_count_o,
    output logic [31:0] drop_count_o
);

    logic [31:0] good_q, good_d;
    logic [31:0] bad_q, bad_d;
    logic [31:0] lost_q, lost_d;
    logic [31:0] drop_q, drop_d;
    logic [15:0] last_index_q, last_index_d;
    logic        has_prev_q, has_prev_d;
    logic [15:0] lost_dist;

    assign lost_dist = frame_index_i - last_index_q - 16'd1;

    always_comb begin
        good_d       = good_q;
        bad_d        = bad_q;
        lost_d       = lost_q;
        drop_d       = drop_q;
        last_index_d = last_index_q;
        has_prev_d   = has_prev_q;
        if (frame_good_i) begin
            good_d       = good_q + 32'd1;
            last_index_d = frame_index_i;
            has_prev_d   = 1'b1;
            // Top bit set means the index went backwards: treat as resync, count nothing.
            if (has_prev_q && !lost_dist[15]) begin
                lost_d = lost_q + {16'd0, lost_dist};
            end
        end
        if (frame_bad_i) begin
            bad_d = bad_q + 32'd1;
        end
        if (frame_drop_i) begin
            drop_d = drop_q + 32'd1;
        end
        // Clear takes priority over any increment landing in the same cycle.
        if (clear_stats_i) begin
            good_d     = 32'd0;
            bad_d      = 32'd0;
            lost_d     = 32'd0;
            drop_d     = 32'd0;
            has_prev_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            good_q       <= 32'd0;
            bad_q        <= 32'd0;
            lost_q       <= 32'd0;
            drop_q       <= 32'd0;
            last_index_q <= 16'd0;
            has_prev_q   <= 1'b0;
        end else begin
            good_q       <= good_d;
            bad_q        <= bad_d;
            lost_q       <= lost_d;
            drop_q       <= drop_d;
            last_index_q <= last_index_d;
            has_prev_q   <= has_prev_d;
        end
    end

    assign good_count_o = good_q;
    assign bad_count_o  = bad_q;
    assign lost_count_o = lost_q;
    assign drop_count_o = drop_q;

endmodule

// File: rtl/test_check_pattern.sv
// Receive-side checker for the 0x88B5 test-pattern stream: validates payload layout,
// extracts timestamp/index, and keeps link statistics.
module test_check_pattern
    import test_check_pattern_pkg::*;
#(
    parameter int DATA_LENGTH = 64,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [47:0]           local_mac,
    input  logic                  clear_stats,
    input  logic                  s_eth_hdr_valid,
    output logic                  s_eth_hdr_ready,
    input  logic [47:0]           s_eth_dest_mac,
    input  logic [47:0]           s_eth_src_mac,
    input  logic [15:0]           s_eth_type,
    input  logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
    input  logic                  s_eth_payload_axis_tvalid,
    output logic                  s_eth_payload_axis_tready,
    input  logic                  s_eth_payload_axis_tlast,
    input  logic                  s_eth_payload_axis_tuser,
    output logic                  rx_done,
    output logic                  rx_ok,
    output logic [15:0]           rx_timestamp,
    output logic [15:0]           rx_packet_index,
    output logic [47:0]           rx_src_mac,
    output logic                  is_timestamp0,
    output logic                  is_timestamp1,
    output logic [31:0]           good_count,
    output logic [31:0]           bad_count,
    output logic [31:0]           lost_count,
    output logic [31:0]           drop_count,
    output logic [2:0]            dbg_state_o
);

    localparam int            CW        = 16;
    localparam logic [CW-1:0] LAST_DATA = CW'(DATA_LENGTH - 1);
    localparam logic [CW-1:0] LAST_ZERO = CW'(ZERO_FIELD_LEN - 1);

    // Handshakes: a beat transfers when valid and ready are both high at the clock edge;
    // header ready only in S_IDLE, payload ready in every other state (no backpressure).
    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;
    logic          long_q, long_d;
    logic [15:0]   ts_q, ts_d;
    logic [15:0]   idx_q, idx_d;
    logic [47:0]   src_q, src_d;
    logic [7:0]    prev_q, prev_d;
    logic          rx_done_q, rx_done_d;
    logic          rx_ok_q, rx_ok_d;
    logic [15:0]   rx_ts_q, rx_ts_d;
    logic [15:0]   rx_idx_q, rx_idx_d;
    logic [47:0]   rx_src_q, rx_src_d;

    logic       fire;
    logic       parse_state;
    logic       byte_err;
    logic       frame_end;
    logic       end_err;
    logic       drop_end;
    logic [7:0] byte_in;

    assign byte_in                   = s_eth_payload_axis_tdata[7:0];
    assign s_eth_hdr_ready           = (state_q == S_IDLE);
    assign s_eth_payload_axis_tready = (state_q != S_IDLE);
    assign fire        = s_eth_payload_axis_tvalid && s_eth_payload_axis_tready;
    assign parse_state = (state_q != S_IDLE) && (state_q != S_DROP);

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        long_d    = long_q;
        ts_d      = ts_q;
        idx_d     = idx_q;
        src_d     = src_q;
        prev_d    = prev_q;
        rx_done_d = 1'b0;
        rx_ok_d   = rx_ok_q;
        rx_ts_d   = rx_ts_q;
        rx_idx_d  = rx_idx_q;
        rx_src_d  = rx_src_q;
        byte_err  = 1'b0;
        frame_end = 1'b0;
        end_err   = 1'b0;
        drop_end  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (s_eth_hdr_valid) begin
                    long_d = 1'b0;
                    err_d  = 1'b0;
                    if (s_eth_type == ETH_TYPE_PATTERN && mac_accepted(s_eth_dest_mac, local_mac)) begin
                        state_d = S_TYPE_FLAG;
                        src_d   = s_eth_src_mac;
                    end else begin
                        state_d = S_DROP;
                    end
                end
            end
            S_TYPE_FLAG: begin
                if (fire) begin
                    byte_err = (byte_in != PATTERN_FLAG);
                    state_d  = S_TIMESTAMP;
                end
            end
            S_TIMESTAMP: begin
                if (fire) begin
                    if (count_q == '0) begin
                        ts_d[7:0] = byte_in;
                    end else begin
                        ts_d[15:8] = byte_in;
                        state_d    = S_3ZEROS;
                    end
                end
            end
            S_3ZEROS: begin
                if (fire) begin
                    byte_err = (byte_in != 8'h00);
                    if (count_q == LAST_ZERO) begin
                        state_d = S_PACKET_INDEX;
                    end
                end
            end
            S_PACKET_INDEX: begin
                if (fire) begin
                    if (count_q == '0) begin
                        idx_d[7:0] = byte_in;
                    end else begin
                        idx_d[15:8] = byte_in;
                        state_d     = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (fire) begin
                    // First data byte seeds the incrementing sequence.
                    if (count_q != '0) begin
                        byte_err = (byte_in != prev_q + 8'd1);
                    end
                    prev_d = byte_in;
                    if (count_q == LAST_DATA && !s_eth_payload_axis_tlast) begin
                        state_d = S_DROP;
                        long_d  = 1'b1;
                    end
                end
            end
            S_DROP: begin
                if (fire && s_eth_payload_axis_tlast) begin
                    state_d = S_IDLE;
                    if (long_q) begin
                        frame_end = 1'b1;
                        end_err   = 1'b1;
                    end else begin
                        drop_end = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (parse_state && fire) begin
            err_d = err_q | byte_err;
            if (s_eth_payload_axis_tlast) begin
                frame_end = 1'b1;
                // Anything but tlast on the final data byte is a short frame.
                end_err   = err_q | byte_err | s_eth_payload_axis_tuser |
                            !(state_q == S_DATA && count_q == LAST_DATA);
                state_d   = S_IDLE;
            end
        end

        if (frame_end) begin
            rx_done_d = 1'b1;
            rx_ok_d   = !end_err;
            rx_ts_d   = ts_d;
            rx_idx_d  = idx_d;
            rx_src_d  = src_q;
        end
    end

    always_comb begin
        count_d = count_q;
        if (state_d != state_q) begin
            count_d = '0;
        end else if (fire) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            err_q     <= 1'b0;
            long_q    <= 1'b0;
            ts_q      <= 16'd0;
            idx_q     <= 16'd0;
            src_q     <= 48'd0;
            prev_q    <= 8'd0;
            rx_done_q <= 1'b0;
            rx_ok_q   <= 1'b0;
            rx_ts_q   <= 16'd0;
            rx_idx_q  <= 16'd0;
            rx_src_q  <= 48'd0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            err_q     <= err_d;
            long_q    <= long_d;
            ts_q      <= ts_d;
            idx_q     <= idx_d;
            src_q     <= src_d;
            prev_q    <= prev_d;
            rx_done_q <= rx_done_d;
            rx_ok_q   <= rx_ok_d;
            rx_ts_q   <= rx_ts_d;
            rx_idx_q  <= rx_idx_d;
            rx_src_q  <= rx_src_d;
        end
    end

    assign is_timestamp0   = (state_q == S_TIMESTAMP) && (count_q == CW'(0)) && fire;
    assign is_timestamp1   = (state_q == S_TIMESTAMP) && (count_q == CW'(1)) && fire;
    assign rx_done         = rx_done_q;
    assign rx_ok           = rx_ok_q;
    assign rx_timestamp    = rx_ts_q;
    assign rx_packet_index = rx_idx_q;
    assign rx_src_mac      = rx_src_q;
    assign dbg_state_o     = state_q;

    test_pattern_stats u_stats (
        .clk           (clk),
        .rst           (rst),
        .clear_stats_i (clear_stats),
        .frame_good_i  (frame_end && !end_err),
        .frame_bad_i   (frame_end && end_err),
        .frame_drop_i  (drop_end),
        .frame_index_i (idx_d),
        .good_count_o  (good_count),
        .bad_count_o   (bad_count),
        .lost_count_o  (lost_count),
        .drop_count_o  (drop_count)
    );

endmodule

// File: tb/tb_test_check_pattern.sv
// Directed vector bench for test_check_pattern: frame table plus reset/clear sequences.
module tb_test_check_pattern;

    localparam int          DL     = 64;
    localparam logic [47:0] LOCAL  = 48'h0211_2233_4455;
    localparam logic [47:0] OTHER  = 48'h0211_2233_4456;
    localparam logic [47:0] BCAST  = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] SRC0   = 48'h0200_0000_0100;

    logic        clk;
    logic        rst;
    logic [47:0] local_mac;
    logic        clear_stats;
    logic        hdr_valid, hdr_ready;
    logic [47:0] dest_mac, src_mac;
    logic [15:0] eth_type;
    logic [7:0]  tdata;
    logic        tvalid, tready, tlast, tuser;
    logic        rx_done, rx_ok, is_ts0, is_ts1;
    logic [15:0] rx_timestamp, rx_packet_index;
    logic [47:0] rx_src_mac;
    logic [31:0] good_count, bad_count, lost_count, drop_count;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    int ts0_hits, ts1_hits, stalls;
    logic [7:0] frame_b[$];

    typedef struct {
        logic [47:0] dest;
        logic [15:0] etype;
        logic [15:0] ts;
        logic [15:0] idx;
        logic [7:0]  seed;
        int          cpos;
        logic [7:0]  cxor;
        int          ldelta;
        logic        tuser_last;
        logic        e_done;
        logic        e_ok;
        logic [31:0] e_good, e_bad, e_lost, e_drop;
    } vec_t;

    vec_t vecs[14];

    test_check_pattern #(.DATA_LENGTH(DL), .DATA_WIDTH(8)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .local_mac                 (local_mac),
        .clear_stats               (clear_stats),
        .s_eth_hdr_valid           (hdr_valid),
        .s_eth_hdr_ready           (hdr_ready),
        .s_eth_dest_mac            (dest_mac),
        .s_eth_src_mac             (src_mac),
        .s_eth_type                (eth_type),
        .s_eth_payload_axis_tdata  (tdata),
        .s_eth_payload_axis_tvalid (tvalid),
        .s_eth_payload_axis_tready (tready),
        .s_eth_payload_axis_tlast  (tlast),
        .s_eth_payload_axis_tuser  (tuser),
        .rx_done                   (rx_done),
        .rx_ok                     (rx_ok),
        .rx_timestamp              (rx_timestamp),
        .rx_packet_index           (rx_packet_index),
        .rx_src_mac                (rx_src_mac),
        .is_timestamp0             (is_ts0),
        .is_timestamp1             (is_ts1),
        .good_count                (good_count),
        .bad_count                 (bad_count),
        .lost_count                (lost_count),
        .drop_count                (drop_count),
        .dbg_state_o               (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic build(input logic [15:0] ts, input logic [15:0] idx, input logic [7:0] seed, input int ndata);
        logic [7:0] b;
        frame_b.delete();
        frame_b.push_back(8'h07);
        frame_b.push_back(ts[7:0]);
        frame_b.push_back(ts[15:8]);
        frame_b.push_back(8'h00);
        frame_b.push_back(8'h00);
        frame_b.push_back(8'h00);
        frame_b.push_back(idx[7:0]);
        frame_b.push_back(idx[15:8]);
        b = seed;
        for (int i = 0; i < ndata; i++) begin
            frame_b.push_back(b);
            b = b + 8'd1;
        end
    endtask

    task automatic send_header(input logic [47:0] dest, input logic [47:0] src, input logic [15:0] etype);
        int w;
        dest_mac  = dest;
        src_mac   = src;
        eth_type  = etype;
        hdr_valid = 1'b1;
        w = 0;
        while (!hdr_ready && w < 20) begin
            tick();
            w++;
        end
        if (w >= 20) check("hdr_ready_timeout", 64'(w), 64'd0);
        tick();
        hdr_valid = 1'b0;
    endtask

    // Drives every byte of frame_b; the caller is left #1 after the tlast edge.
    task automatic send_frame(input logic [47:0] dest, input logic [47:0] src, input logic [15:0] etype,
                              input logic tuser_last, input logic clr_last);
        send_header(dest, src, etype);
        ts0_hits = 0;
        ts1_hits = 0;
        stalls   = 0;
        for (int i = 0; i < frame_b.size(); i++) begin
            tvalid      = 1'b1;
            tdata       = frame_b[i];
            tlast       = (i == frame_b.size() - 1);
            tuser       = tlast && tuser_last;
            clear_stats = tlast && clr_last;
            #1;
            if (is_ts0) ts0_hits++;
            if (is_ts1) ts1_hits++;
            if (!tready) stalls++;
            tick();
        end
        tvalid      = 1'b0;
        tlast       = 1'b0;
        tuser       = 1'b0;
        clear_stats = 1'b0;
    endtask

    task automatic check_counts(input string tag, input logic [31:0] g, input logic [31:0] b,
                                input logic [31:0] l, input logic [31:0] d);
        check({tag, "_good"}, 64'(good_count), 64'(g));
        check({tag, "_bad"},  64'(bad_count),  64'(b));
        check({tag, "_lost"}, 64'(lost_count), 64'(l));
        check({tag, "_drop"}, 64'(drop_count), 64'(d));
    endtask

    initial begin
        rst = 1'b1; local_mac = LOCAL; clear_stats = 1'b0;
        hdr_valid = 1'b0; dest_mac = '0; src_mac = '0; eth_type = '0;
        tdata = '0; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;

        //                dest   etype     ts        idx       seed   cpos cxor  ldel tu done ok good bad lost drop
        vecs[0]  = '{LOCAL, 16'h88B5, 16'h1234, 16'h0005, 8'h40, -1, 8'h00, 0,   0, 1, 1, 1, 0, 0, 0};
        vecs[1]  = '{LOCAL, 16'h88B5, 16'h2000, 16'h0009, 8'h10, -1, 8'h00, 0,   0, 1, 1, 2, 0, 3, 0};
        vecs[2]  = '{LOCAL, 16'h88B5, 16'h2001, 16'h0002, 8'h20, -1, 8'h00, 0,   0, 1, 1, 3, 0, 3, 0};
        vecs[3]  = '{LOCAL, 16'h88B5, 16'h3000, 16'h0003, 8'h00, 18, 8'hFF, 0,   0, 1, 0, 3, 1, 3, 0};
        vecs[4]  = '{LOCAL, 16'h88B5, 16'h3001, 16'h0003, 8'h00, 0,  8'h01, 0,   0, 1, 0, 3, 2, 3, 0};
        vecs[5]  = '{LOCAL, 16'h88B5, 16'h3002, 16'h0003, 8'h00, -1, 8'h00, -33, 0, 1, 0, 3, 3, 3, 0};
        vecs[6]  = '{LOCAL, 16'h88B5, 16'h3003, 16'h0003, 8'h00, -1, 8'h00, 4,   0, 1, 0, 3, 4, 3, 0};
        vecs[7]  = '{LOCAL, 16'h88B5, 16'h4000, 16'h0003, 8'h55, -1, 8'h00, 0,   0, 1, 1, 4, 4, 3, 0};
        vecs[8]  = '{LOCAL, 16'h0800, 16'h4001, 16'h0004, 8'h00, -1, 8'h00, 0,   0, 0, 0, 4, 4, 3, 1};
        vecs[9]  = '{OTHER, 16'h88B5, 16'h4002, 16'h0004, 8'h00, -1, 8'h00, 0,   0, 0, 0, 4, 4, 3, 2};
        vecs[10] = '{BCAST, 16'h88B5, 16'h5000, 16'h0006, 8'hE0, -1, 8'h00, 0,   0, 1, 1, 5, 4, 5, 2};
        vecs[11] = '{LOCAL, 16'h88B5, 16'h5001, 16'h0007, 8'h00, -1, 8'h00, 0,   1, 1, 0, 5, 5, 5, 2};
        vecs[12] = '{LOCAL, 16'h88B5, 16'h6000, 16'hFFFF, 8'hFF, -1, 8'h00, 0,   0, 1, 1, 6, 5, 5, 2};
        vecs[13] = '{LOCAL, 16'h88B5, 16'h6001, 16'h0001, 8'h80, -1, 8'h00, 0,   0, 1, 1, 7, 5, 6, 2};

        repeat (3) tick();
        check("rst_hdr_ready", 64'(hdr_ready), 64'd1);
        check("rst_tready", 64'(tready), 64'd0);
        check("rst_rx_done", 64'(rx_done), 64'd0);
        check("rst_rx_ok", 64'(rx_ok), 64'd0);
        check("rst_rx_fields", {16'(rx_timestamp), 48'(rx_src_mac)} | 64'(rx_packet_index), 64'd0);
        check_counts("rst", 0, 0, 0, 0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 14; v++) begin
            string tag;
            tag = $sformatf("v%0d", v);
            build(vecs[v].ts, vecs[v].idx, vecs[v].seed, DL + vecs[v].ldelta);
            if (vecs[v].cpos >= 0) frame_b[vecs[v].cpos] = frame_b[vecs[v].cpos] ^ vecs[v].cxor;
            send_frame(vecs[v].dest, SRC0 + 48'(v), vecs[v].etype, vecs[v].tuser_last, 1'b0);
            check({tag, "_done"}, 64'(rx_done), 64'(vecs[v].e_done));
            check({tag, "_stalls"}, 64'(stalls), 64'd0);
            check({tag, "_ts_strobes"}, 64'({ts0_hits[7:0], ts1_hits[7:0]}),
                  vecs[v].e_done ? 64'h0101 : 64'h0000);
            if (vecs[v].e_done) begin
                check({tag, "_ok"}, 64'(rx_ok), 64'(vecs[v].e_ok));
                check({tag, "_ts"}, 64'(rx_timestamp), 64'(vecs[v].ts));
                check({tag, "_idx"}, 64'(rx_packet_index), 64'(vecs[v].idx));
                check({tag, "_src"}, 64'(rx_src_mac), 64'(SRC0 + 48'(v)));
            end
            check_counts(tag, vecs[v].e_good, vecs[v].e_bad, vecs[v].e_lost, vecs[v].e_drop);
            check({tag, "_state_idle"}, 64'(dbg_state), 64'd0);
            tick();
            check({tag, "_done_pulse"}, 64'(rx_done), 64'd0);
        end

        // clear_stats on the tlast beat: the frame is reported but its increment is discarded.
        build(16'h7000, 16'd100, 8'h00, DL);
        send_frame(LOCAL, SRC0, 16'h88B5, 1'b0, 1'b1);
        check("clr_done", 64'(rx_done), 64'd1);
        check("clr_ok", 64'(rx_ok), 64'd1);
        check_counts("clr", 0, 0, 0, 0);
        tick();
        build(16'h7001, 16'd200, 8'h00, DL);
        send_frame(LOCAL, SRC0, 16'h88B5, 1'b0, 1'b0);
        check_counts("clr_first", 1, 0, 0, 0);
        tick();
        build(16'h7002, 16'd202, 8'h00, DL);
        send_frame(LOCAL, SRC0, 16'h88B5, 1'b0, 1'b0);
        check_counts("clr_second", 2, 0, 1, 0);
        tick();

        // Reset in the middle of the data field.
        build(16'h5555, 16'h0010, 8'h00, DL);
        send_header(LOCAL, SRC0, 16'h88B5);
        for (int i = 0; i < 28; i++) begin
            tvalid = 1'b1;
            tdata  = frame_b[i];
            tick();
        end
        check("mid_state_data", 64'(dbg_state), 64'd5);
        rst   = 1'b1;
        tdata = frame_b[28];
        tick();
        rst = 1'b0;
        check("mrst_hdr_ready", 64'(hdr_ready), 64'd1);
        check("mrst_tready", 64'(tready), 64'd0);
        check("mrst_rx_ok", 64'(rx_ok), 64'd0);
        check("mrst_rx_done", 64'(rx_done), 64'd0);
        check("mrst_rx_ts", 64'(rx_timestamp), 64'd0);
        check("mrst_rx_idx", 64'(rx_packet_index), 64'd0);
        check("mrst_rx_src", 64'(rx_src_mac), 64'd0);
        check_counts("mrst", 0, 0, 0, 0);
        for (int i = 29; i < 32; i++) begin
            tdata = frame_b[i];
            #1;
            check($sformatf("mrst_no_accept%0d", i), 64'(tready), 64'd0);
            tick();
        end
        tvalid = 1'b0;
        send_frame(LOCAL, SRC0, 16'h88B5, 1'b0, 1'b0);
        check("post_rst_done", 64'(rx_done), 64'd1);
        check("post_rst_ok", 64'(rx_ok), 64'd1);
        check_counts("post_rst", 1, 0, 0, 0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
